// File: rtl/div8_seq.sv
// div8_seq: 8-bit signed/unsigned restoring divider; start/signed_op/A/B in, busy/done/result{rem,quo}/div_by_zero/ovf out
module div8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_by_zero,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic neg_a, neg_b, ovf_l, fits;
  logic [7:0] q, r, d, a_mag, b_mag;
  logic [8:0] r_sh, r_sub;
  logic [3:0] cnt;
  always_comb begin
    state_nx = state == IDLE ? (start ? (B == 8'h00 ? DONE : CALC) : IDLE) :
               state == CALC ? (cnt == 4'd7 ? FIX : CALC) :
               state == FIX  ? DONE : IDLE;
    a_mag = (signed_op && A[7]) ? 8'(-A) : A;
    b_mag = (signed_op && B[7]) ? 8'(-B) : B;
    r_sh  = {r, q[7]};
    r_sub = r_sh - {1'b0, d};
    fits  = !r_sub[8];
    busy  = state != IDLE;
    done  = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {neg_a, neg_b, ovf_l, q, r, d, cnt} <= '0;
      {result, div_by_zero, ovf} <= '0;
    end else if (state == IDLE && start) begin
      neg_a <= signed_op && A[7];
      neg_b <= signed_op && B[7];
      ovf_l <= signed_op && A == 8'h80 && B == 8'hFF;
      q <= a_mag;
      d <= b_mag;
      r <= 8'h00;
      cnt <= 4'd0;
      if (B == 8'h00) begin
        result <= {A, 8'hFF};
        div_by_zero <= 1'b1;
        ovf <= 1'b0;
      end
    end else if (state == CALC) begin
      r <= fits ? r_sub[7:0] : r_sh[7:0];
      q <= {q[6:0], fits};
      cnt <= cnt + 4'd1;
    end else if (state == FIX) begin
      result <= {neg_a ? 8'(-r) : r, (neg_a ^ neg_b) ? 8'(-q) : q};
      div_by_zero <= 1'b0;
      ovf <= ovf_l;
    end
  end
endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: randomized and directed checks of div8_seq against an arithmetic reference model
module tb_div8_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_op = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic busy, done, div_by_zero, ovf;
  logic [15:0] result;
  int checks = 0, failures = 0;
  div8_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .A(A), .B(B),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int qi, ri, sa, sb;
    if (b == 8'h00) return {1'b0, 1'b1, a, 8'hFF};
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    if (s && sa == -128 && sb == -1) return {1'b1, 1'b0, 16'h0080};
    qi = sa / sb;
    ri = sa % sb;
    return {1'b0, 1'b0, 8'(ri), 8'(qi)};
  endfunction
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    logic [17:0] exp = model(a, b, s);
    int lat = 1;
    @(negedge clk);
    A = a; B = b; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'($urandom); B = 8'($urandom); signed_op = 1'($urandom);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      start = lat == 3;
      A = 8'($urandom); B = 8'($urandom);
    end
    start = 1'b0;
    chk({tag, ".latency"}, lat, b == 8'h00 ? 1 : 10);
    chk({tag, ".result"}, result, exp[15:0]);
    chk({tag, ".dbz"}, div_by_zero, exp[16]);
    chk({tag, ".ovf"}, ovf, exp[17]);
    chk({tag, ".busy_done"}, busy, 1);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {busy, done}, 2'b00);
    chk({tag, ".hold"}, {ovf, div_by_zero, result}, exp);
  endtask
  task automatic b2b(input logic [7:0] b, input int period, input string tag);
    int n = 0;
    @(negedge clk);
    A = 8'h64; B = b; signed_op = 1'b0; start = 1'b1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    chk({tag, ".period"}, n, period);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset.outs", {busy, done, div_by_zero, ovf, result}, 0);
    rst = 1'b0;
    do_op(8'hC8, 8'h07, 1'b0, "u200_7");
    do_op(8'hF9, 8'h02, 1'b1, "s-7_2");
    do_op(8'h07, 8'hFE, 1'b1, "s7_-2");
    do_op(8'hF9, 8'hFE, 1'b1, "s-7_-2");
    do_op(8'h55, 8'h00, 1'b0, "u_dbz");
    do_op(8'h55, 8'h00, 1'b1, "s_dbz");
    do_op(8'h80, 8'hFF, 1'b1, "s_ovf");
    do_op(8'h80, 8'hFF, 1'b0, "u128_255");
    do_op(8'h80, 8'h01, 1'b1, "s-128_1");
    b2b(8'h07, 11, "b2b_calc");
    b2b(8'h00, 2, "b2b_dbz");
    @(negedge clk);
    A = 8'hC8; B = 8'h07; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.outs", {busy, done, div_by_zero, ovf, result}, 0);
    do_op(8'hC8, 8'h07, 1'b0, "after_abort");
    @(negedge clk);
    A = 8'h10; B = 8'h03; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_vs_start", {busy, done}, 2'b00);
    for (int i = 0; i < 250; i++) begin
      logic [7:0] a = 8'($urandom), b = 8'($urandom);
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'($urandom_range(1, 3));
        default: ;
      endcase
      do_op(a, b, 1'($urandom), "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
